// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronized input, mid-bit sampling, frame-error detect.
// A line held low after a frame parks the FSM in CLEANUP so a break never starts a frame.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       i_Clock,
    input  logic       i_Reset_n,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Frame_Err
);

    localparam logic [14:0] HALF_BIT = 15'((CLKS_PER_BIT - 1) >> 1);
    localparam logic [14:0] BIT_LAST = 15'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } state_t;

    logic        rx_meta_reg, rx_s_reg;
    state_t      state_reg, state_next;
    logic [14:0] count_reg, count_next;
    logic [2:0]  index_reg, index_next;
    logic [7:0]  data_reg, data_next;
    logic [7:0]  byte_reg, byte_next;
    logic        dv_reg, dv_next;
    logic        fe_reg, fe_next;
    logic        active_reg, active_next;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
            state_reg   <= IDLE;
            count_reg   <= '0;
            index_reg   <= '0;
            data_reg    <= '0;
            byte_reg    <= '0;
            dv_reg      <= 1'b0;
            fe_reg      <= 1'b0;
            active_reg  <= 1'b0;
        end else begin
            rx_meta_reg <= i_Rx_Serial;
            rx_s_reg    <= rx_meta_reg;
            state_reg   <= state_next;
            count_reg   <= count_next;
            index_reg   <= index_next;
            data_reg    <= data_next;
            byte_reg    <= byte_next;
            dv_reg      <= dv_next;
            fe_reg      <= fe_next;
            active_reg  <= active_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        index_next = index_reg;
        data_next  = data_reg;
        byte_next  = byte_reg;
        dv_next    = 1'b0;
        fe_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                count_next = '0;
                index_next = '0;
                if (!rx_s_reg)
                    state_next = START;
            end
            START: begin
                // A start bit that is gone by mid-bit is treated as a glitch
                if (count_reg == HALF_BIT) begin
                    count_next = '0;
                    state_next = rx_s_reg ? IDLE : DATA;
                end else begin
                    count_next = count_reg + 15'd1;
                end
            end
            DATA: begin
                if (count_reg == BIT_LAST) begin
                    count_next           = '0;
                    data_next[index_reg] = rx_s_reg;
                    if (index_reg == 3'd7) begin
                        index_next = '0;
                        state_next = STOP;
                    end else begin
                        index_next = index_reg + 3'd1;
                    end
                end else begin
                    count_next = count_reg + 15'd1;
                end
            end
            STOP: begin
                if (count_reg == BIT_LAST) begin
                    count_next = '0;
                    state_next = CLEANUP;
                    if (rx_s_reg) begin
                        dv_next   = 1'b1;
                        byte_next = data_reg;
                    end else begin
                        fe_next = 1'b1;
                    end
                end else begin
                    count_next = count_reg + 15'd1;
                end
            end
            CLEANUP: begin
                if (rx_s_reg)
                    state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
                index_next = '0;
            end
        endcase
        active_next = (state_next == START) || (state_next == DATA) || (state_next == STOP);
    end

    assign o_Rx_DV     = dv_reg;
    assign o_Rx_Byte   = byte_reg;
    assign o_Rx_Active = active_reg;
    assign o_Frame_Err = fe_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one main receiver at 8 clocks/bit plus receivers at 4, 9 and 434.
// A negedge monitor logs DV bytes/cycles and pulse counts; the main thread compares them.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] rx_line;
    logic       dv_w [4];
    logic [7:0] byte_w [4];
    logic       active_w [4];
    logic       fe_w [4];

    int cpb_of [4] = '{8, 4, 9, 434};

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(8)) u_dut (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Rx_Serial(rx_line[0]),
        .o_Rx_DV(dv_w[0]), .o_Rx_Byte(byte_w[0]), .o_Rx_Active(active_w[0]), .o_Frame_Err(fe_w[0]));
    uart_rx #(.CLKS_PER_BIT(4)) u_c4 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Rx_Serial(rx_line[1]),
        .o_Rx_DV(dv_w[1]), .o_Rx_Byte(byte_w[1]), .o_Rx_Active(active_w[1]), .o_Frame_Err(fe_w[1]));
    uart_rx #(.CLKS_PER_BIT(9)) u_c9 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Rx_Serial(rx_line[2]),
        .o_Rx_DV(dv_w[2]), .o_Rx_Byte(byte_w[2]), .o_Rx_Active(active_w[2]), .o_Frame_Err(fe_w[2]));
    uart_rx #(.CLKS_PER_BIT(434)) u_c434 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Rx_Serial(rx_line[3]),
        .o_Rx_DV(dv_w[3]), .o_Rx_Byte(byte_w[3]), .o_Rx_Active(active_w[3]), .o_Frame_Err(fe_w[3]));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] got_q [4][$];
    int         dv_cyc_q [$];
    int         fe_cnt [4] = '{0, 0, 0, 0};
    int         act_cnt = 0;
    int         both_cnt = 0;

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (dv_w[k]) got_q[k].push_back(byte_w[k]);
            if (fe_w[k]) fe_cnt[k] <= fe_cnt[k] + 1;
            if (dv_w[k] && fe_w[k]) both_cnt <= both_cnt + 1;
        end
        if (dv_w[0]) dv_cyc_q.push_back(cyc);
        if (active_w[0]) act_cnt <= act_cnt + 1;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called on a negedge; holds the line for the given number of clocks.
    task automatic drive(input int sel, input logic val, input int cycles);
        rx_line[sel] = val;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] b, input logic stop_bit,
                              input int gap, output int start_cyc);
        int cpb;
        cpb = cpb_of[sel];
        start_cyc = cyc;
        drive(sel, 1'b0, cpb);
        for (int i = 0; i < 8; i++) drive(sel, b[i], cpb);
        drive(sel, stop_bit, cpb);
        if (gap > 0) drive(sel, 1'b1, gap);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        logic [7:0] exp_byte;
        int         exp_lat;   // drive-to-DV clocks: 3 sync/detect + 76 frame
    } vec_t;

    vec_t vecs [5];
    int   starts [5];
    int   n_dv, n_fe, a0, s;
    logic [31:0] act;
    logic [7:0]  b;
    logic [7:0]  exp_q [4][$];

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 20, 8'hA5, 79};
        vecs[1] = '{8'h00, 1'b1,  0, 8'h00, 79};
        vecs[2] = '{8'hFF, 1'b1, 16, 8'hFF, 79};
        vecs[3] = '{8'hC3, 1'b1,  3, 8'hC3, 79};
        vecs[4] = '{8'h96, 1'b1, 10, 8'h96, 79};

        rst_n   = 1'b0;
        rx_line = 4'hF;
        repeat (3) @(negedge clk);
        check("reset_dv",     dv_w[0],     1'b0);
        check("reset_fe",     fe_w[0],     1'b0);
        check("reset_active", active_w[0], 1'b0);
        check("reset_byte",   byte_w[0],   8'h00);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Valid frames, including a back-to-back pair (0x00 then 0xFF)
        for (int i = 0; i < 5; i++)
            send_frame(0, vecs[i].data, vecs[i].stop, vecs[i].gap, starts[i]);
        repeat (20) @(negedge clk);
        check("vec_dv_count", got_q[0].size(), 5);
        for (int i = 0; i < 5; i++) begin
            act = (i < got_q[0].size()) ? 32'(got_q[0][i]) : 'x;
            check($sformatf("vec%0d_byte", i), act, vecs[i].exp_byte);
            act = (i < dv_cyc_q.size()) ? 32'(dv_cyc_q[i] - starts[i]) : 'x;
            check($sformatf("vec%0d_latency", i), act, vecs[i].exp_lat);
        end
        check("vec_no_frame_err", fe_cnt[0], 0);

        // Two-clock low glitch: START for 4 cycles, then back to IDLE silently
        n_dv = got_q[0].size();
        a0   = act_cnt;
        drive(0, 1'b0, 2);
        drive(0, 1'b1, 20);
        check("glitch_active_cycles", act_cnt - a0, 4);
        check("glitch_no_dv", got_q[0].size(), n_dv);
        check("glitch_no_fe", fe_cnt[0], 0);
        check("glitch_byte_held", byte_w[0], 8'h96);

        // Stop bit low, line held low 40 clocks: one frame error, no new frame
        n_fe = fe_cnt[0];
        send_frame(0, 8'h3C, 1'b0, 0, s);
        drive(0, 1'b0, 15);
        a0 = act_cnt;
        drive(0, 1'b0, 25);
        check("break_no_restart", act_cnt - a0, 0);
        check("ferr_pulse_count", fe_cnt[0] - n_fe, 1);
        check("ferr_no_dv", got_q[0].size(), n_dv);
        check("ferr_byte_held", byte_w[0], 8'h96);
        drive(0, 1'b1, 10);
        send_frame(0, 8'h81, 1'b1, 10, s);
        check("after_break_dv", got_q[0].size(), n_dv + 1);
        check("after_break_byte", byte_w[0], 8'h81);
        check("after_break_fe", fe_cnt[0] - n_fe, 1);

        // Reset in the middle of data bit 4, then a clean frame
        n_dv = got_q[0].size();
        n_fe = fe_cnt[0];
        b = 8'hE7;
        drive(0, 1'b0, 8);
        for (int i = 0; i < 4; i++) drive(0, b[i], 8);
        drive(0, b[4], 4);
        rst_n = 1'b0;
        #1;
        check("midrst_dv",     dv_w[0],     1'b0);
        check("midrst_fe",     fe_w[0],     1'b0);
        check("midrst_active", active_w[0], 1'b0);
        check("midrst_byte",   byte_w[0],   8'h00);
        rx_line[0] = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_no_dv", got_q[0].size(), n_dv);
        check("midrst_no_fe", fe_cnt[0], n_fe);
        send_frame(0, 8'h5A, 1'b1, 10, s);
        check("postrst_dv", got_q[0].size(), n_dv + 1);
        check("postrst_byte", byte_w[0], 8'h5A);

        // Bit-time sweep with random bytes; 4 clocks/bit runs back-to-back
        for (int k = 1; k < 4; k++) begin
            for (int f = 0; f < ((k == 3) ? 3 : 5); f++) begin
                b = 8'($urandom_range(0, 255));
                exp_q[k].push_back(b);
                send_frame(k, b, 1'b1, (k == 1) ? 0 : cpb_of[k], s);
            end
            repeat (2 * cpb_of[k] + 10) @(negedge clk);
            check($sformatf("sweep%0d_dv_count", cpb_of[k]), got_q[k].size(), exp_q[k].size());
            for (int i = 0; i < exp_q[k].size(); i++) begin
                act = (i < got_q[k].size()) ? 32'(got_q[k][i]) : 'x;
                check($sformatf("sweep%0d_byte%0d", cpb_of[k], i), act, exp_q[k][i]);
            end
            check($sformatf("sweep%0d_no_fe", cpb_of[k]), fe_cnt[k], 0);
        end

        check("dv_fe_never_together", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
